// File: rtl/pwm_array_pkg.sv
// pwm_array_pkg: shared defaults, types and helpers for the PWM array controller.
// Optional linear fade is selected with the PWM_FADE_EN macro (see pwm_array_ctrl).
package pwm_array_pkg;

  localparam int CH_DEF    = 24;
  localparam int PWM_W_DEF = 8;

  // Duty value at the default resolution
  typedef logic [PWM_W_DEF-1:0] duty_t;

  // Commit sequencing: wait for a boundary, then (optionally) fade to target
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_FADE = 2'd2
  } commit_state_e;

  // Period length in cycles; also the duty value meaning "always on"
  function automatic int unsigned periodMax(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: one PWM lane with shadow/active duty, sticky fault latch and
// registered comparator output. With PWM_FADE_EN defined, the active duty walks
// one LSB per boundary toward a target captured at commit.
module pwm_channel import pwm_array_pkg::*; #(
  parameter int PWM_W = PWM_W_DEF
) (
  input  logic             sys_clk,
  input  logic             sys_resetb,
  input  logic             en_i,
  input  logic [PWM_W-1:0] cnt_i,
  input  logic             wrSel_i,
  input  logic [PWM_W-1:0] wrDuty_i,
  input  logic             load_i,
`ifdef PWM_FADE_EN
  input  logic             step_i,
  output logic             atTarget_o,
`endif
  input  logic             fault_i,
  input  logic             faultClr_i,
  output logic             pwm_o,
  output logic             fault_o,
  output logic [PWM_W-1:0] duty_o
);

  logic [PWM_W-1:0] shadow_q, shadow_d;
  logic [PWM_W-1:0] active_q, active_d;
  logic             fault_q, fault_d;
  logic             pwm_q, pwm_d;
`ifdef PWM_FADE_EN
  logic [PWM_W-1:0] target_q, target_d;
  logic [PWM_W-1:0] stepGoal;
`endif

  // Next state: shadow capture, active update at boundaries, fault latch (set wins), comparator
  always_comb begin
    shadow_d = wrSel_i ? wrDuty_i : shadow_q;
`ifdef PWM_FADE_EN
    target_d = load_i ? shadow_q : target_q;
    stepGoal = load_i ? shadow_q : target_q;
    active_d = active_q;
    if (load_i || step_i) begin
      if (active_q < stepGoal) begin
        active_d = active_q + PWM_W'(1);
      end else if (active_q > stepGoal) begin
        active_d = active_q - PWM_W'(1);
      end
    end
`else
    active_d = load_i ? shadow_q : active_q;
`endif
    fault_d = fault_i | (fault_q & ~faultClr_i);
    pwm_d   = en_i & ~fault_q & (cnt_i < active_q);
  end

  // Channel state registers
  always_ff @(posedge sys_clk or negedge sys_resetb) begin
    if (!sys_resetb) begin
      shadow_q <= '0;
      active_q <= '0;
      fault_q  <= 1'b0;
      pwm_q    <= 1'b0;
`ifdef PWM_FADE_EN
      target_q <= '0;
`endif
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      fault_q  <= fault_d;
      pwm_q    <= pwm_d;
`ifdef PWM_FADE_EN
      target_q <= target_d;
`endif
    end
  end

`ifdef PWM_FADE_EN
  assign atTarget_o = (active_q == target_q);
`endif
  assign pwm_o   = pwm_q;
  assign fault_o = fault_q;
  assign duty_o  = active_q;

endmodule

// File: rtl/pwm_array_ctrl.sv
// pwm_array_ctrl: N-channel double-buffered PWM engine. Holds the period counter,
// the commit FSM and the write decode; per-channel logic lives in pwm_channel.
// Define PWM_FADE_EN to make commits fade one LSB per period instead of jumping.
module pwm_array_ctrl import pwm_array_pkg::*; #(
  parameter  int CH    = CH_DEF,
  parameter  int PWM_W = PWM_W_DEF,
  localparam int CHW   = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                sys_clk,
  input  logic                sys_resetb,
  input  logic                en,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [CHW-1:0]      wr_ch,
  input  logic [PWM_W-1:0]    wr_duty,
  input  logic                commit,
  input  logic [CH-1:0]       fault_i,
  input  logic [CH-1:0]       fault_clr,
  output logic [CH-1:0]       pwm_o,
  output logic [CH-1:0]       fault_o,
  output logic                period_start_o,
  output logic                commit_pend_o,
  output logic [CH*PWM_W-1:0] duty_o
);

  localparam logic [PWM_W-1:0] CNT_MAX = PWM_W'(periodMax(PWM_W) - 32'd1);

  commit_state_e    state_q, state_d;
  logic [PWM_W-1:0] cnt_q, cnt_d;
  logic             periodStart_q, periodStart_d;
  logic             boundary;
  logic             load;
  logic             wrAccept;
`ifdef PWM_FADE_EN
  logic             step;
  logic [CH-1:0]    atTarget;
`endif

  // Counter runs 0..CNT_MAX while enabled; boundary is the last count or any disabled cycle
  always_comb begin
    boundary      = !en || (cnt_q == CNT_MAX);
    cnt_d         = (!en || (cnt_q == CNT_MAX)) ? '0 : cnt_q + PWM_W'(1);
    periodStart_d = en && (cnt_q == '0);
  end

  // Commit FSM: a commit waits for the next boundary; repeated commits while busy are ignored
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
`ifdef PWM_FADE_EN
    step    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (commit) state_d = ST_PEND;
      end
      ST_PEND: begin
        if (boundary) begin
          load = 1'b1;
`ifdef PWM_FADE_EN
          state_d = ST_FADE;
`else
          state_d = ST_IDLE;
`endif
        end
      end
`ifdef PWM_FADE_EN
      ST_FADE: begin
        if (&atTarget) begin
          state_d = ST_IDLE;
        end else if (boundary) begin
          step = 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Counter, period-start flag and FSM state registers
  always_ff @(posedge sys_clk or negedge sys_resetb) begin
    if (!sys_resetb) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      periodStart_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      periodStart_q <= periodStart_d;
    end
  end

  assign wr_ready       = (state_q == ST_IDLE);
  assign commit_pend_o  = ~wr_ready;
  assign period_start_o = periodStart_q;
  assign wrAccept       = wr_valid && wr_ready && (int'(wr_ch) < CH);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic wrSel;
    assign wrSel = wrAccept && (int'(wr_ch) == i);

    pwm_channel #(.PWM_W(PWM_W)) u_ch (
      .sys_clk    (sys_clk),
      .sys_resetb (sys_resetb),
      .en_i       (en),
      .cnt_i      (cnt_q),
      .wrSel_i    (wrSel),
      .wrDuty_i   (wr_duty),
      .load_i     (load),
`ifdef PWM_FADE_EN
      .step_i     (step),
      .atTarget_o (atTarget[i]),
`endif
      .fault_i    (fault_i[i]),
      .faultClr_i (fault_clr[i]),
      .pwm_o      (pwm_o[i]),
      .fault_o    (fault_o[i]),
      .duty_o     (duty_o[i*PWM_W +: PWM_W])
    );
  end

endmodule
